// File: rtl/store_buffer_ctrl.sv
// store_buffer_ctrl: in-order store buffer for the memory stage.
// Retiring stores are queued and drained one at a time to the data-memory
// write port over a req/ack handshake. Loads are forwarded from the youngest
// exact-match entry or stalled on a partial/mismatched overlap.
// Instruction ID encodings are local to this block and must track the decoder.
module store_buffer_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [5:0]  st_instr_id,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [5:0]  ld_instr_id,
  input  logic [31:0] ld_addr,
  output logic        ld_fwd_valid,
  output logic [31:0] ld_fwd_data,
  output logic        ld_stall,
  input  logic        drain_req,
  output logic        empty,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_strb,
  input  logic        mem_wr_ack
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [5:0] INSTR_LB  = 6'd10;
  localparam logic [5:0] INSTR_LH  = 6'd11;
  localparam logic [5:0] INSTR_LW  = 6'd12;
  localparam logic [5:0] INSTR_LBU = 6'd13;
  localparam logic [5:0] INSTR_LHU = 6'd14;
  localparam logic [5:0] INSTR_SB  = 6'd15;
  localparam logic [5:0] INSTR_SH  = 6'd16;
  localparam logic [5:0] INSTR_SW  = 6'd17;

  localparam logic [1:0] SZ_B    = 2'd0;
  localparam logic [1:0] SZ_H    = 2'd1;
  localparam logic [1:0] SZ_W    = 2'd2;
  localparam logic [1:0] SZ_NONE = 2'd3;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  // Access size of a store ID; SZ_NONE for anything that is not a store.
  function automatic logic [1:0] store_size(input logic [5:0] id);
    case (id)
      INSTR_SB: store_size = SZ_B;
      INSTR_SH: store_size = SZ_H;
      INSTR_SW: store_size = SZ_W;
      default:  store_size = SZ_NONE;
    endcase
  endfunction

  // Access size of a load ID; SZ_NONE for anything that is not a load.
  function automatic logic [1:0] load_size(input logic [5:0] id);
    case (id)
      INSTR_LB, INSTR_LBU: load_size = SZ_B;
      INSTR_LH, INSTR_LHU: load_size = SZ_H;
      INSTR_LW:            load_size = SZ_W;
      default:             load_size = SZ_NONE;
    endcase
  endfunction

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] lane_strb(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    lane_strb = 4'b0001 << lo;
      SZ_H:    lane_strb = 4'b0011 << {lo[1], 1'b0};
      SZ_W:    lane_strb = 4'b1111;
      default: lane_strb = 4'b0000;
    endcase
  endfunction

  // Unshifted store data moved onto its byte lanes.
  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [1:0] lo,
                                            input logic [31:0] d);
    case (sz)
      SZ_B:    lane_data = 32'(d[7:0]) << {lo, 3'b000};
      SZ_H:    lane_data = 32'(d[15:0]) << {lo[1], 4'b0000};
      default: lane_data = d;
    endcase
  endfunction

  logic [5:0]       ent_id   [DEPTH];
  logic [31:0]      ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drain_block_q;
  logic [0:0]       state_q, state_d;

  logic             full, push, pop;
  logic [1:0]       head_sz;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = !full && !drain_block_q;
  assign push     = st_valid && st_ready && (store_size(st_instr_id) != SZ_NONE);
  assign pop      = (state_q == WRITE) && mem_wr_ack;
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  assign head_sz  = store_size(ent_id[head_q]);

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Drain FSM next state and write-port outputs from the head entry.
  always_comb begin
    state_d     = state_q;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_wr_strb = '0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = WRITE;
      end
      WRITE: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = {ent_addr[head_q][31:2], 2'b00};
        mem_wr_data = lane_data(head_sz, ent_addr[head_q][1:0], ent_data[head_q]);
        mem_wr_strb = lane_strb(head_sz, ent_addr[head_q][1:0]);
        if (pop && (count_d == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Queue pointers, occupancy and fence blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      drain_block_q <= 1'b0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      count_q <= count_d;
      if (drain_req)           drain_block_q <= 1'b1;
      else if (count_d == '0)  drain_block_q <= 1'b0;
    end
  end

  // Entry payload write; contents are don't-care outside the live window.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_id[tail_q]   <= st_instr_id;
      ent_addr[tail_q] <= st_addr;
      ent_data[tail_q] <= st_data;
    end
  end

  logic [1:0]       ld_sz;
  logic [3:0]       ld_strb;
  logic             ld_active, hit, hit_exact, st_same;
  logic [31:0]      hit_data;
  logic [PTR_W-1:0] idx;
  logic [1:0]       ent_sz;

  // Load lookup: scan oldest to youngest so the youngest overlap wins.
  always_comb begin
    ld_sz        = load_size(ld_instr_id);
    ld_strb      = lane_strb(ld_sz, ld_addr[1:0]);
    ld_active    = ld_valid && (ld_sz != SZ_NONE);
    hit          = 1'b0;
    hit_exact    = 1'b0;
    hit_data     = '0;
    idx          = '0;
    ent_sz       = SZ_NONE;
    ld_fwd_valid = 1'b0;
    ld_fwd_data  = '0;
    ld_stall     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        idx    = head_q + PTR_W'(i);
        ent_sz = store_size(ent_id[idx]);
        if ((ent_addr[idx][31:2] == ld_addr[31:2]) &&
            ((lane_strb(ent_sz, ent_addr[idx][1:0]) & ld_strb) != 4'b0000)) begin
          hit       = 1'b1;
          hit_exact = (ent_addr[idx] == ld_addr) && (ent_sz == ld_sz);
          hit_data  = ent_data[idx];
        end
      end
    end
    st_same = st_valid && (store_size(st_instr_id) != SZ_NONE) &&
              (st_addr[31:2] == ld_addr[31:2]) &&
              ((lane_strb(store_size(st_instr_id), st_addr[1:0]) & ld_strb) != 4'b0000);
    if (ld_active) begin
      if (st_same || (hit && !hit_exact)) begin
        ld_stall = 1'b1;
      end else if (hit) begin
        ld_fwd_valid = 1'b1;
        case (ld_instr_id)
          INSTR_LB:  ld_fwd_data = {{24{hit_data[7]}}, hit_data[7:0]};
          INSTR_LBU: ld_fwd_data = {24'h000000, hit_data[7:0]};
          INSTR_LH:  ld_fwd_data = {{16{hit_data[15]}}, hit_data[15:0]};
          INSTR_LHU: ld_fwd_data = {16'h0000, hit_data[15:0]};
          default:   ld_fwd_data = hit_data;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Directed bench for store_buffer_ctrl: forwarding, extension, stalls,
// drain ordering, full/fence blocking and reset during a drain.
module tb_store_buffer_ctrl;

  localparam logic [5:0] INSTR_LB  = 6'd10;
  localparam logic [5:0] INSTR_LH  = 6'd11;
  localparam logic [5:0] INSTR_LW  = 6'd12;
  localparam logic [5:0] INSTR_LBU = 6'd13;
  localparam logic [5:0] INSTR_SB  = 6'd15;
  localparam logic [5:0] INSTR_SW  = 6'd17;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [5:0]  st_instr_id;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [5:0]  ld_instr_id;
  logic [31:0] ld_addr;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic        ld_stall;
  logic        drain_req;
  logic        empty;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic        mem_wr_ack;

  int n_vec = 0;
  int n_err = 0;

  store_buffer_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_instr_id(st_instr_id), .st_addr(st_addr),
    .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_instr_id(ld_instr_id), .ld_addr(ld_addr),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall),
    .drain_req(drain_req), .empty(empty),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_strb(mem_wr_strb), .mem_wr_ack(mem_wr_ack)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports miscompares.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [5:0] id, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_instr_id = id; st_addr = a; st_data = d;
  endtask

  task automatic load(input logic [5:0] id, input logic [31:0] a);
    ld_valid = 1'b1; ld_instr_id = id; ld_addr = a;
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_instr_id = '0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_instr_id = '0; ld_addr = '0; drain_req = 1'b0; mem_wr_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_st_ready", 32'(st_ready), 32'd1);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check_eq("rst_wr_addr", mem_wr_addr, 32'd0);
    check_eq("rst_wr_data", mem_wr_data, 32'd0);
    check_eq("rst_wr_strb", 32'(mem_wr_strb), 32'd0);
    check_eq("rst_fwd", {30'd0, ld_fwd_valid, ld_stall}, 32'd0);
    check_eq("rst_fwd_data", ld_fwd_data, 32'd0);
    rst = 1'b0;

    // Forward word
    @(negedge clk); store(INSTR_SW, 32'h100, 32'hDEADBEEF);
    @(negedge clk); st_valid = 1'b0; load(INSTR_LW, 32'h100); #1;
    check_eq("fw_valid", 32'(ld_fwd_valid), 32'd1);
    check_eq("fw_data", ld_fwd_data, 32'hDEADBEEF);
    check_eq("fw_stall", 32'(ld_stall), 32'd0);
    check_eq("fw_empty", 32'(empty), 32'd0);
    check_eq("fw_wr_en_n1", 32'(mem_wr_en), 32'd0);
    @(negedge clk); #1;
    check_eq("fw_wr_en_n2", 32'(mem_wr_en), 32'd1);
    check_eq("fw_wr_addr", mem_wr_addr, 32'h100);
    check_eq("fw_wr_data", mem_wr_data, 32'hDEADBEEF);
    check_eq("fw_wr_strb", 32'(mem_wr_strb), 32'hF);
    mem_wr_ack = 1'b1;
    @(negedge clk); mem_wr_ack = 1'b0; #1;
    check_eq("fw_drained_empty", 32'(empty), 32'd1);
    check_eq("fw_drained_en", 32'(mem_wr_en), 32'd0);
    check_eq("fw_after_drain", {30'd0, ld_fwd_valid, ld_stall}, 32'd0);

    // Byte extend, same-cycle store stall, partial-overlap stall
    @(negedge clk); store(INSTR_SB, 32'h103, 32'h000000F0); load(INSTR_LB, 32'h103); #1;
    check_eq("be_same_cycle_stall", 32'(ld_stall), 32'd1);
    check_eq("be_same_cycle_fwd", 32'(ld_fwd_valid), 32'd0);
    @(negedge clk); st_valid = 1'b0; #1;
    check_eq("be_lb_valid", 32'(ld_fwd_valid), 32'd1);
    check_eq("be_lb_data", ld_fwd_data, 32'hFFFFFFF0);
    ld_instr_id = INSTR_LBU; #1;
    check_eq("be_lbu_data", ld_fwd_data, 32'h000000F0);
    load(INSTR_LH, 32'h102); #1;
    check_eq("be_lh_partial_stall", {30'd0, ld_fwd_valid, ld_stall}, 32'd1);
    @(negedge clk); ld_valid = 1'b0; #1;
    check_eq("be_wr_en", 32'(mem_wr_en), 32'd1);
    check_eq("be_wr_strb", 32'(mem_wr_strb), 32'h8);
    check_eq("be_wr_data", mem_wr_data, 32'hF0000000);
    check_eq("be_wr_addr", mem_wr_addr, 32'h100);
    check_eq("be_no_load_data", ld_fwd_data, 32'd0);
    mem_wr_ack = 1'b1;
    @(negedge clk); mem_wr_ack = 1'b0; #1;
    check_eq("be_drained_empty", 32'(empty), 32'd1);

    // Type mismatch stall held until the entry pops
    @(negedge clk); store(INSTR_SB, 32'h200, 32'h55);
    @(negedge clk); st_valid = 1'b0; load(INSTR_LW, 32'h200); #1;
    check_eq("tm_stall_n1", {30'd0, ld_fwd_valid, ld_stall}, 32'd1);
    @(negedge clk); mem_wr_ack = 1'b1; #1;
    check_eq("tm_stall_ack_cycle", {30'd0, ld_fwd_valid, ld_stall}, 32'd1);
    @(negedge clk); mem_wr_ack = 1'b0; #1;
    check_eq("tm_stall_released", {30'd0, ld_fwd_valid, ld_stall}, 32'd0);
    check_eq("tm_empty", 32'(empty), 32'd1);
    ld_valid = 1'b0;

    // Youngest wins, back-to-back drain with ack held high
    @(negedge clk); mem_wr_ack = 1'b1; store(INSTR_SW, 32'h300, 32'd1);
    @(negedge clk); store(INSTR_SW, 32'h300, 32'd2);
    @(negedge clk); st_valid = 1'b0; load(INSTR_LW, 32'h300); #1;
    check_eq("yw_fwd_data", ld_fwd_data, 32'd2);
    check_eq("yw_wr1_en", 32'(mem_wr_en), 32'd1);
    check_eq("yw_wr1_data", mem_wr_data, 32'd1);
    @(negedge clk); #1;
    check_eq("yw_wr2_en", 32'(mem_wr_en), 32'd1);
    check_eq("yw_wr2_data", mem_wr_data, 32'd2);
    check_eq("yw_fwd_data2", ld_fwd_data, 32'd2);
    @(negedge clk); mem_wr_ack = 1'b0; ld_valid = 1'b0; #1;
    check_eq("yw_idle_en", 32'(mem_wr_en), 32'd0);
    check_eq("yw_empty", 32'(empty), 32'd1);

    // Full buffer (pointers wrap) and fence blocking
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); store(INSTR_SW, 32'h400 + 32'(4 * i), 32'(i));
    end
    @(negedge clk); store(INSTR_SW, 32'h500, 32'h99); #1;
    check_eq("ff_full_ready", 32'(st_ready), 32'd0);
    @(negedge clk); st_valid = 1'b0; load(INSTR_LW, 32'h500); #1;
    check_eq("ff_5th_not_pushed", {30'd0, ld_fwd_valid, ld_stall}, 32'd0);
    load(INSTR_LW, 32'h40C); #1;
    check_eq("ff_wrapped_fwd", ld_fwd_data, 32'd3);
    drain_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drain_req = 1'b0; ld_valid = 1'b0; mem_wr_ack = 1'b1; #1;
      check_eq("ff_fence_ready", 32'(st_ready), 32'd0);
      check_eq("ff_fence_addr", mem_wr_addr, 32'h400 + 32'(4 * k));
      check_eq("ff_fence_data", mem_wr_data, 32'(k));
    end
    @(negedge clk); mem_wr_ack = 1'b0; #1;
    check_eq("ff_empty", 32'(empty), 32'd1);
    check_eq("ff_ready_back", 32'(st_ready), 32'd1);
    check_eq("ff_idle_en", 32'(mem_wr_en), 32'd0);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); store(INSTR_SW, 32'h700 + 32'(4 * i), 32'hA0 + 32'(i));
    end
    @(negedge clk); st_valid = 1'b0; #1;
    check_eq("rd_wr_en_before", 32'(mem_wr_en), 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check_eq("rd_wr_en", 32'(mem_wr_en), 32'd0);
    check_eq("rd_empty", 32'(empty), 32'd1);
    check_eq("rd_st_ready", 32'(st_ready), 32'd1);
    @(negedge clk); load(INSTR_LW, 32'h700); #1;
    check_eq("rd_no_rewrite", 32'(mem_wr_en), 32'd0);
    check_eq("rd_entries_gone", {30'd0, ld_fwd_valid, ld_stall}, 32'd0);
    ld_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
